sync_filter: RTL and testbench
==============================

# sync_filter

Multi-channel synchronizer with per-channel glitch filtering and edge detection. Each bit of an asynchronous input bus passes through a `Stages`-deep flop chain into the `clk_i` domain. A change is then accepted only after it has been stable for `FilterCycles` consecutive cycles. Each accepted change produces a single-cycle rise or fall pulse. The block sits at chip or cluster boundaries for pins, interrupts and status lines that need clean, debounced, edge-qualified signals.

## Interface
- `Width`, default 1: number of independent channels.
- `Stages`, default 2: synchronizer depth; must be ≥ 2.
- `ResetValue`, default 1'b0: reset level of every sync flop and of `serial_o`; applies to all channels.
- `FilterCycles`, default 4: consecutive stable cycles required to accept a change; must be ≥ 1.
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `serial_i`  in  Width  asynchronous inputs.
- `serial_o`  out  Width  synchronized, filtered level.
- `rise_o`  out  Width  one-cycle pulse when `serial_o[i]` goes 0→1.
- `fall_o`  out  Width  one-cycle pulse when `serial_o[i]` goes 1→0.
- `glitch_o`  out  Width  one-cycle pulse when a pending change is rejected.

## Operation
- The block has no cross-channel interaction. All behaviour below applies per channel `i`.
- **Sync chain:** `Stages` flops, reset to `ResetValue`. Mark each flop `(* async *)` and the chain `(* dont_touch = "true" *)`. The chain output is `s`.
- **Filter state:**
  - `f` is the filtered level register and drives `serial_o[i]`.
  - `cnt` is a counter of width `$clog2(FilterCycles+1)`.
- **Filter update, each cycle:**
  - `s == f`:
    - `cnt <= 0`.
    - If `cnt != 0` on this cycle, pulse `glitch_o[i]` (the pending change is rejected).
  - `s != f` and `cnt == FilterCycles-1`:
    - `f <= s`, `cnt <= 0`.
    - Pulse `rise_o[i]` or `fall_o[i]`, depending on `s`.
  - `s != f` otherwise: `cnt <= cnt + 1`.
- **Implicit states per channel:** STABLE (`cnt == 0`) and PENDING (`cnt > 0`).
  - PENDING→STABLE happens either by accept (edge pulse) or by reject (glitch pulse).
  - Both cannot occur in the same cycle.
- **`FilterCycles == 1`:** `f` follows `s` with one cycle of delay. `glitch_o` never pulses.
- **Pulses are registered:**
  - `rise_o`, `fall_o` and `glitch_o` are flops.
  - `rise_o`/`fall_o` assert in the same cycle `serial_o` shows the new level.
  - For each channel, `rise_o`, `fall_o` and `glitch_o` are mutually exclusive in any cycle.
- **Reset:**
  - Asserting `rst_ni` asynchronously forces all sync flops and `f` to `ResetValue`, and forces `cnt`, `rise_o`, `fall_o` and `glitch_o` to 0, even mid-count.
  - No pulse is generated by reset assertion or release.
  - If `serial_i` differs from `ResetValue` after release, it is accepted as a normal edge after the full latency.

## Timing
- **Accept latency:** `serial_i` held at a new level from before edge 1 updates `serial_o` and pulses `rise_o`/`fall_o` after exactly `Stages + FilterCycles` rising edges.
- **Pulse width:** `rise_o`, `fall_o` and `glitch_o` are high for exactly one cycle.
- **Rejection:** an input level held for fewer than `FilterCycles` cycles at the chain output is rejected. `glitch_o` pulses `Stages + k + 1` edges after the change, where k is the held length (1 ≤ k < FilterCycles).
- **Throughput:** back-to-back accepted edges on one channel are at least `FilterCycles` cycles apart.
- **Metastability:** only the first sync flop may sample a changing input. Everything downstream is fully synchronous.

## Configuration
- Macro: `SYNC_FILTER_GLITCH_EN`.
- **Defined:** filter as described above.
- **Undefined:**
  - `cnt` and the filter logic are removed.
  - `f <= s` every cycle; `FilterCycles` is ignored.
  - Accept latency is `Stages + 1` edges.
  - `glitch_o` is tied to 0.
  - `rise_o`/`fall_o` still pulse on every change of `f`.

## Test plan
All scenarios use `Width=4`, `Stages=2`, `FilterCycles=4`, `ResetValue=0` unless stated.
1. **Reset:** assert `rst_ni` with `serial_i=4'hF`.
   - Required: `serial_o`, `rise_o`, `fall_o` and `glitch_o` are all 0, asynchronously and without a clock edge.
   - After release, `serial_o` becomes `4'hF` after 6 edges, with `rise_o=4'hF` for one cycle.
2. **Rise/fall on channel 0:**
   - Drive `serial_i[0]` to 1 before edge 1 → `serial_o[0]=1` and `rise_o[0]` pulses after edge 6.
   - Drive it back to 0 → `fall_o[0]` pulses 6 edges later.
   - Other channels stay quiet.
3. **Glitch on channel 1:** drive `serial_i[1]` high for 3 cycles, then low.
   - Required: `serial_o[1]` stays 0, no `rise_o[1]`.
   - Required: `glitch_o[1]` pulses once, 6 edges after the rise.
   - Repeat with a 4-cycle hold → accepted, `rise_o[1]` pulses.
4. **Simultaneous edges:** set `serial_o[3]=1` beforehand, then change channel 2 0→1 and channel 3 1→0 in the same cycle.
   - Required: `rise_o[2]` and `fall_o[3]` both pulse in the same cycle.
5. **Reset mid-count:** start a change on channel 0, then assert `rst_ni` when `cnt` = 2.
   - Required: no pulses.
   - Required: on release, the counter restarts from 0 and the full 6-edge latency applies.
6. **Macro undefined:** build without `SYNC_FILTER_GLITCH_EN` and drive a 1-cycle pulse on `serial_i[0]`.
   - Required: `serial_o[0]` is high for one cycle, 3 edges later.
   - Required: `rise_o[0]` and `fall_o[0]` pulse on consecutive cycles; `glitch_o` stays 0.

Source files
------------

// File: rtl/sync_filter.sv
// Per-channel synchronizer, stability filter and edge detector for asynchronous pins.
// Define SYNC_FILTER_GLITCH_EN to enable the FilterCycles debounce; otherwise the level follows the chain output.
module sync_filter #(
  parameter int   Width        = 1,
  parameter int   Stages       = 2,
  parameter logic ResetValue   = 1'b0,
  parameter int   FilterCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] serial_i,
  output logic [Width-1:0] serial_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] glitch_o
);

  if (Stages < 2 || FilterCycles < 1) begin : g_bad_param
    $error("sync_filter: Stages must be >= 2 and FilterCycles >= 1");
  end

  (* dont_touch = "true" *) (* async *) logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Stages; k++) sync_q[k] <= {Width{ResetValue}};
    end else begin
      sync_q[0] <= serial_i;
      for (int k = 1; k < Stages; k++) sync_q[k] <= sync_q[k-1];
    end
  end

`ifdef SYNC_FILTER_GLITCH_EN
  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FilterCycles - 1);

  // Filter stage: a change on s is accepted only after FilterCycles stable cycles
  for (genvar i = 0; i < Width; i++) begin : g_ch
    logic            s;
    logic            f_q;
    logic            rise_q;
    logic            fall_q;
    logic            glitch_q;
    logic [CntW-1:0] cnt_q;

    assign s = sync_q[Stages-1][i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        f_q      <= ResetValue;
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
        if (s == f_q) begin
          cnt_q    <= '0;
          glitch_q <= (cnt_q != '0);
        end else if (cnt_q == LastCnt) begin
          f_q    <= s;
          cnt_q  <= '0;
          rise_q <= s;
          fall_q <= ~s;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end

    assign serial_o[i] = f_q;
    assign rise_o[i]   = rise_q;
    assign fall_o[i]   = fall_q;
    assign glitch_o[i] = glitch_q;
  end
`else
  logic [Width-1:0] f_q;
  logic [Width-1:0] rise_q;
  logic [Width-1:0] fall_q;

  // Edge stage: level register follows the chain output one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_q    <= {Width{ResetValue}};
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      f_q    <= sync_q[Stages-1];
      rise_q <= sync_q[Stages-1] & ~f_q;
      fall_q <= ~sync_q[Stages-1] & f_q;
    end
  end

  assign serial_o = f_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign glitch_o = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter (Width=4, Stages=2, FilterCycles=4) with a history-based reference model.
module tb_sync_filter;

  localparam int W      = 4;
  localparam int STAGES = 2;
  localparam int MAXN   = 2048;
`ifdef SYNC_FILTER_GLITCH_EN
  localparam int FCM = 4;
  localparam int LAT = 6;
`else
  localparam int FCM = 1;
  localparam int LAT = 3;
`endif

  logic         clk_i;
  logic         rst_ni;
  logic [W-1:0] serial_i;
  logic [W-1:0] serial_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] glitch_o;

  sync_filter #(
    .Width       (W),
    .Stages      (STAGES),
    .ResetValue  (1'b0),
    .FilterCycles(4)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .serial_i(serial_i),
    .serial_o(serial_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .glitch_o(glitch_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input history per edge, chain output is the input delayed by the chain depth.
  logic [W-1:0] in_hist [MAXN];
  int           n;
  int           seg [W];
  logic [W-1:0] mf, erise, efall, eglitch;

  function automatic logic s_at(input int m, input int ch);
    int idx;
    idx = m - STAGES + 1;
    if (idx < 0 || idx >= MAXN) return 1'b0;
    return in_hist[idx][ch];
  endfunction

  task automatic model_edge();
    int  run;
    logic v;
    erise = '0; efall = '0; eglitch = '0;
    for (int ch = 0; ch < W; ch++) begin
      v = s_at(n - 1, ch);
      if (v != mf[ch]) begin
        run = 0;
        for (int j = n - 1; j >= seg[ch] && run < FCM; j--) begin
          if (s_at(j, ch) != mf[ch]) run++;
          else break;
        end
        if (run >= FCM) begin
          mf[ch]    = v;
          seg[ch]   = n;
          erise[ch] = v;
          efall[ch] = ~v;
        end
      end else if (n - 2 >= seg[ch] && s_at(n - 2, ch) != mf[ch]) begin
        eglitch[ch] = 1'b1;
      end
    end
  endtask

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      n = 0;
      in_hist[0] = '0;
      mf = '0; erise = '0; efall = '0; eglitch = '0;
      for (int ch = 0; ch < W; ch++) seg[ch] = 0;
    end else if (n < MAXN - 1) begin
      n++;
      in_hist[n] = serial_i;
      model_edge();
    end
    #1;
    chk("model_serial", serial_o, mf);
    chk("model_rise", rise_o, erise);
    chk("model_fall", fall_o, efall);
    chk("model_glitch", glitch_o, eglitch);
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  initial begin
    rst_ni   = 1'b0;
    serial_i = 4'hF;
    step(3);
    chk("rst_serial", serial_o, 4'h0);
    chk("rst_rise", rise_o, 4'h0);
    chk("rst_fall", fall_o, 4'h0);
    chk("rst_glitch", glitch_o, 4'h0);

    rst_ni = 1'b1;
    step(LAT - 1);
    chk("t1_before_lat", serial_o, 4'h0);
    chk("t1_no_early_rise", rise_o, 4'h0);
    step(1);
    chk("t1_serial", serial_o, 4'hF);
    chk("t1_rise", rise_o, 4'hF);
    step(1);
    chk("t1_rise_width", rise_o, 4'h0);

    rst_ni = 1'b0;
    #1;
    chk("t1_async_serial", serial_o, 4'h0);
    chk("t1_async_rise", rise_o, 4'h0);
    chk("t1_async_fall", fall_o, 4'h0);
    serial_i = 4'h0;
    step(2);
    rst_ni = 1'b1;
    step(LAT + 2);

    serial_i = 4'h1;
    step(LAT - 1);
    chk("t2_before_lat", serial_o, 4'h0);
    step(1);
    chk("t2_serial", serial_o, 4'h1);
    chk("t2_rise", rise_o, 4'h1);
    chk("t2_fall_quiet", fall_o, 4'h0);
    step(1);
    chk("t2_rise_width", rise_o, 4'h0);
    step(3);
    serial_i = 4'h0;
    step(LAT);
    chk("t2_fall", fall_o, 4'h1);
    chk("t2_serial_low", serial_o, 4'h0);
    step(3);

`ifdef SYNC_FILTER_GLITCH_EN
    serial_i = 4'h2;
    step(3);
    serial_i = 4'h0;
    step(2);
    chk("t3_glitch_early", glitch_o, 4'h0);
    step(1);
    chk("t3_glitch", glitch_o, 4'h2);
    chk("t3_serial", serial_o, 4'h0);
    chk("t3_no_rise", rise_o, 4'h0);
    step(1);
    chk("t3_glitch_width", glitch_o, 4'h0);
    step(4);
    serial_i = 4'h2;
    step(4);
    serial_i = 4'h0;
    step(2);
    chk("t3_accept_rise", rise_o, 4'h2);
    chk("t3_accept_serial", serial_o, 4'h2);
    chk("t3_accept_no_glitch", glitch_o, 4'h0);
    step(8);
`endif

    serial_i = 4'h8;
    step(LAT + 2);
    chk("t4_setup", serial_o, 4'h8);
    serial_i = 4'h4;
    step(LAT);
    chk("t4_rise", rise_o, 4'h4);
    chk("t4_fall", fall_o, 4'h8);
    chk("t4_serial", serial_o, 4'h4);
    step(3);
    serial_i = 4'h0;
    step(LAT + 2);

    serial_i = 4'h1;
    step(4);
    rst_ni = 1'b0;
    #1;
    chk("t5_async_serial", serial_o, 4'h0);
    chk("t5_async_rise", rise_o, 4'h0);
    chk("t5_async_glitch", glitch_o, 4'h0);
    step(2);
    rst_ni = 1'b1;
    step(LAT - 1);
    chk("t5_restart_serial", serial_o, 4'h0);
    chk("t5_restart_rise", rise_o, 4'h0);
    step(1);
    chk("t5_rise", rise_o, 4'h1);
    chk("t5_serial", serial_o, 4'h1);
    step(3);
    serial_i = 4'h0;
    step(LAT + 2);

`ifndef SYNC_FILTER_GLITCH_EN
    serial_i = 4'h1;
    step(1);
    serial_i = 4'h0;
    step(2);
    chk("t6_serial_high", serial_o, 4'h1);
    chk("t6_rise", rise_o, 4'h1);
    chk("t6_fall_quiet", fall_o, 4'h0);
    step(1);
    chk("t6_serial_low", serial_o, 4'h0);
    chk("t6_fall", fall_o, 4'h1);
    chk("t6_rise_done", rise_o, 4'h0);
    chk("t6_glitch", glitch_o, 4'h0);
    step(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
